pipe_robot_controller: RTL and testbench

- Autonomous controller for a pipe-cleaning robot moving on a grid maze. It uses a left-hand wall-following rule.
- Each clock it reads four environment sensors and issues at most one action: step forward, rotate 90° left, or a removal pulse.
- It sits under the world/environment model. The world refreshes the sensors from the robot's position and applies the actions to the map.

---
 rtl/pipe_robot_controller_if.sv | 33 +++
 rtl/pipe_robot_controller.sv | 132 +++++++++++++
 tb/tb_pipe_robot_controller.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_robot_controller_if.sv
// Sensor/action bundle between the pipe robot controller and its world model.
// The robot controller is the master: it reads sensors and drives actions.
`timescale 1ns/1ps

interface pipe_robot_controller_if;
  logic head;
  logic left;
  logic under;
  logic barrier;
  logic front;
  logic turn;
  logic remove;

  modport master (
    input  head,
    input  left,
    input  under,
    input  barrier,
    output front,
    output turn,
    output remove
  );

  modport slave (
    output head,
    output left,
    output under,
    output barrier,
    input  front,
    input  turn,
    input  remove
  );
endinterface

// File: rtl/pipe_robot_controller.sv
// Left-hand wall-following controller for a pipe-cleaning robot.
// Registered Moore outputs: at most one of front/turn/remove per step.
`timescale 1ns/1ps

module pipe_robot_controller #(
  parameter int REMOVE_CYCLES = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  pipe_robot_controller_if.master bus
);

  localparam int CW = (REMOVE_CYCLES < 1) ? 1 : $clog2(REMOVE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(REMOVE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] DECIDE         = 3'd0;
  localparam logic [2:0] FWD_AFTER_LEFT = 3'd1;
  localparam logic [2:0] RIGHT2         = 3'd2;
  localparam logic [2:0] RIGHT3         = 3'd3;
  localparam logic [2:0] REMOVING       = 3'd4;
  localparam logic [2:0] SETTLE         = 3'd5;
  localparam logic [2:0] HALT           = 3'd6;

  // A single-pulse removal goes straight to the settle cycle.
  localparam logic [2:0] AFTER_FIRST_PULSE = (REMOVE_CYCLES <= 1) ? SETTLE : REMOVING;

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          front_n;
  logic          turn_n;
  logic          remove_n;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    front_n  = 1'b0;
    turn_n   = 1'b0;
    remove_n = 1'b0;

    case (state)
      DECIDE: begin
        if (bus.under) begin
          state_n = HALT;
        end else if (!bus.left) begin
          turn_n  = 1'b1;
          state_n = FWD_AFTER_LEFT;
        end else if (bus.barrier) begin
          remove_n = 1'b1;
          cnt_n    = CNT_ONE;
          state_n  = AFTER_FIRST_PULSE;
        end else if (!bus.head) begin
          front_n = 1'b1;
        end else begin
          turn_n  = 1'b1;
          state_n = RIGHT2;
        end
      end

      // Left is ignored here so a fresh opening cannot cause endless spinning.
      FWD_AFTER_LEFT: begin
        if (bus.under) begin
          state_n = HALT;
        end else if (bus.barrier) begin
          remove_n = 1'b1;
          cnt_n    = CNT_ONE;
          state_n  = AFTER_FIRST_PULSE;
        end else if (!bus.head) begin
          front_n = 1'b1;
          state_n = DECIDE;
        end else begin
          state_n = DECIDE;
        end
      end

      RIGHT2: begin
        turn_n  = 1'b1;
        state_n = RIGHT3;
      end

      RIGHT3: begin
        turn_n  = 1'b1;
        state_n = DECIDE;
      end

      REMOVING: begin
        if (cnt < CNT_MAX) begin
          remove_n = 1'b1;
          cnt_n    = cnt + CNT_ONE;
          if (cnt == CNT_MAX - CNT_ONE) begin
            state_n = SETTLE;
          end
        end else begin
          state_n = SETTLE;
        end
      end

      SETTLE: begin
        cnt_n   = '0;
        state_n = DECIDE;
      end

      HALT: begin
        state_n = HALT;
      end

      default: begin
        cnt_n   = '0;
        state_n = DECIDE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= DECIDE;
      cnt        <= '0;
      bus.front  <= 1'b0;
      bus.turn   <= 1'b0;
      bus.remove <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bus.front  <= front_n;
      bus.turn   <= turn_n;
      bus.remove <= remove_n;
    end
  end

endmodule

// File: tb/tb_pipe_robot_controller.sv
// Randomised scoreboard bench for pipe_robot_controller against an action-plan model.
`timescale 1ns/1ps

module tb_pipe_robot_controller;

  localparam int N = 3;

  localparam int A_IDLE   = 0;
  localparam int A_FRONT  = 1;
  localparam int A_TURN   = 2;
  localparam int A_REMOVE = 3;
  localparam int A_AFTERL = 4;

  logic clock;
  logic reset;

  pipe_robot_controller_if bus();

  pipe_robot_controller #(.REMOVE_CYCLES(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] exp_q[$];
  string      name_q[$];

  int plan[$];
  bit halted;

  function automatic logic [2:0] enc(int a);
    case (a)
      A_FRONT:  return 3'b100;
      A_TURN:   return 3'b010;
      A_REMOVE: return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    plan.delete();
    halted = 1'b0;
  endtask

  // The robot's future is a plan of queued actions; sensors only matter when the plan is empty.
  task automatic model_step(input bit h, input bit l, input bit u, input bit b,
                            output logic [2:0] act);
    bit after_left;
    act = 3'b000;
    if (halted) begin
      act = 3'b000;
    end else if (plan.size() > 0 && plan[0] != A_AFTERL) begin
      act = enc(plan.pop_front());
    end else begin
      after_left = (plan.size() > 0);
      if (after_left) void'(plan.pop_front());
      if (u) begin
        halted = 1'b1;
      end else if (!after_left && !l) begin
        act = enc(A_TURN);
        plan.push_back(A_AFTERL);
      end else if (b) begin
        act = enc(A_REMOVE);
        for (int i = 1; i < N; i++) plan.push_back(A_REMOVE);
        plan.push_back(A_IDLE);
      end else if (!h) begin
        act = enc(A_FRONT);
      end else if (!after_left) begin
        act = enc(A_TURN);
        plan.push_back(A_TURN);
        plan.push_back(A_TURN);
      end
    end
  endtask

  function automatic logic [2:0] outs();
    return {bus.front, bus.turn, bus.remove};
  endfunction

  task automatic checkOutput(input string what, input logic [2:0] got, input logic [2:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got {front,turn,remove}=%b, expected %b at %0t", what, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input bit h, input bit l, input bit u, input bit b, input string what);
    logic [2:0] e;
    bus.head    = h;
    bus.left    = l;
    bus.under   = u;
    bus.barrier = b;
    model_step(h, l, u, b, e);
    exp_q.push_back(e);
    name_q.push_back(what);
  endtask

  task automatic step(input bit h, input bit l, input bit u, input bit b, input string what);
    @(negedge clock);
    applyStimulus(h, l, u, b, what);
  endtask

  task automatic step_random(input string what, input bit allow_under);
    step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
         allow_under && ($urandom_range(0, 40) == 0),
         $urandom_range(0, 3) == 0, what);
  endtask

  task automatic reset_now();
    reset = 1'b1;
    #1;
    checkOutput("async_reset", outs(), 3'b000);
    model_reset();
  endtask

  task automatic release_with(input bit h, input bit l, input bit u, input bit b, input string what);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(h, l, u, b, what);
  endtask

  // Monitor: outputs settle just after each rising edge and are compared with the queued expectation.
  always @(posedge clock) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      checkOutput(name_q.pop_front(), outs(), exp_q.pop_front());
    end
  end

  initial begin
    reset       = 1'b1;
    bus.head    = 1'b0;
    bus.left    = 1'b0;
    bus.under   = 1'b0;
    bus.barrier = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    checkOutput("reset_state", outs(), 3'b000);

    release_with(0, 1, 0, 0, "corridor");
    repeat (3) step(0, 1, 0, 0, "corridor");

    step(1, 1, 0, 0, "corner_turn1");
    step_random("corner_turn2", 1'b0);
    step_random("corner_turn3", 1'b0);
    step(0, 1, 0, 0, "corner_front");

    step(0, 0, 0, 0, "left_open_turn");
    step(0, 0, 0, 0, "left_open_front");
    step(0, 1, 0, 0, "left_open_decide");

    step(0, 1, 0, 1, "trash_pulse1");
    step_random("trash_pulse2", 1'b0);
    step_random("trash_pulse3", 1'b0);
    step_random("trash_settle", 1'b0);
    step(0, 1, 0, 0, "trash_front");

    for (int i = 0; i < 400; i++) step_random("random_walk", 1'b0);

    step(0, 1, 1, 0, "goal_halt");
    for (int i = 0; i < 20; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, "halted");

    @(negedge clock);
    reset_now();
    release_with(0, 1, 0, 1, "rst_trash_pulse1");
    step_random("rst_trash_pulse2", 1'b0);
    @(posedge clock);
    #3;
    reset_now();
    release_with(0, 1, 0, 1, "restart_pulse1");
    step_random("restart_pulse2", 1'b0);
    step_random("restart_pulse3", 1'b0);
    step_random("restart_settle", 1'b0);
    step(0, 1, 0, 0, "restart_front");

    for (int i = 0; i < 600; i++) begin
      step_random("random_mix", 1'b1);
      if ($urandom_range(0, 60) == 0) begin
        @(posedge clock);
        #($urandom_range(2, 4));
        reset_now();
        release_with($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 1'b0,
                     $urandom_range(0, 3) == 0, "after_random_reset");
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
